// File: rtl/mpsoc_noc_arb_pkg.sv
// Shared types and helpers for the NoC packet arbiter.
package mpsoc_noc_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  // Round-robin candidate index: (base + off) wrapped into [0, ports).
  function automatic int unsigned rr_index(int unsigned base, int unsigned off,
                                           int unsigned ports);
    return (base + off) % ports;
  endfunction

endpackage

// File: rtl/mpsoc_noc_rr_select.sv
// Combinational round-robin picker: first set req bit searching upward from ptr+1.
module mpsoc_noc_rr_select
  import mpsoc_noc_arb_pkg::*;
#(
  parameter int unsigned PORTS = 4
) (
  input  logic [PORTS-1:0]         req,
  input  logic [$clog2(PORTS)-1:0] ptr,
  output logic [$clog2(PORTS)-1:0] sel,
  output logic                     any
);

  localparam int unsigned PTR_W = $clog2(PORTS);

  logic [PTR_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int unsigned off = PORTS; off >= 1; off--) begin
      idx = PTR_W'(rr_index(32'(ptr), off, PORTS));
      if (req[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpsoc_noc_packet_arbiter.sv
// Packet-level round-robin arbiter sharing one NoC link among local requesters,
// with a one-stage output register toward the mesh router.
module mpsoc_noc_packet_arbiter
  import mpsoc_noc_arb_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned PORTS      = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [PORTS-1:0][FLIT_WIDTH-1:0] in_flit,
  input  logic [PORTS-1:0]                 in_last,
  input  logic [PORTS-1:0]                 in_valid,
  output logic [PORTS-1:0]                 in_ready,
  output logic [FLIT_WIDTH-1:0]            out_flit,
  output logic                             out_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [PORTS-1:0]                 grant
);

  localparam int unsigned PTR_W = $clog2(PORTS);

  arb_state_t             state, state_next;
  logic [PTR_W-1:0]       owner, owner_next;
  logic [PTR_W-1:0]       ptr, ptr_next;
  logic [PTR_W-1:0]       rr_sel;
  logic                   rr_any;
  logic [PORTS-1:0]       grant_next;
  logic [FLIT_WIDTH-1:0]  out_flit_next;
  logic                   out_last_next;
  logic                   out_valid_next;
  logic                   accept;

  mpsoc_noc_rr_select #(
    .PORTS(PORTS)
  ) u_rr_select (
    .req(in_valid),
    .ptr(ptr),
    .sel(rr_sel),
    .any(rr_any)
  );

  // State and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      owner     <= '0;
      ptr       <= PTR_W'(PORTS - 1);
      grant     <= '0;
      out_flit  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      owner     <= owner_next;
      ptr       <= ptr_next;
      grant     <= grant_next;
      out_flit  <= out_flit_next;
      out_last  <= out_last_next;
      out_valid <= out_valid_next;
    end
  end

  // Arbitration, ownership lock and output-stage update.
  always_comb begin
    state_next     = state;
    owner_next     = owner;
    ptr_next       = ptr;
    grant_next     = grant;
    out_flit_next  = out_flit;
    out_last_next  = out_last;
    out_valid_next = out_valid;
    in_ready       = '0;
    accept         = 1'b0;

    unique case (state)
      ARB_IDLE: begin
        if (rr_any) begin
          state_next = ARB_BUSY;
          owner_next = rr_sel;
          grant_next = PORTS'(1) << rr_sel;
        end
      end
      ARB_BUSY: begin
        in_ready[owner] = !out_valid || out_ready;
        accept          = in_valid[owner] && in_ready[owner];
        // Lock released only once the tail flit has been taken.
        if (accept && in_last[owner]) begin
          state_next = ARB_IDLE;
          ptr_next   = owner;
          grant_next = '0;
        end
      end
      default: state_next = ARB_IDLE;
    endcase

    if (accept) begin
      out_flit_next  = in_flit[owner];
      out_last_next  = in_last[owner];
      out_valid_next = 1'b1;
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

endmodule

// File: doc/mpsoc_noc_packet_arbiter.md
# mpsoc_noc_packet_arbiter

Packet-level round-robin arbiter that shares one NoC link channel (flit/last/valid/ready) among several local requesters inside a tile. Examples of requesters are the network adapter DMA, the message-passing endpoint and the debug bridge. Once a requester wins, it holds the link until its `last` flit has been accepted, so wormhole packets are never interleaved. A one-stage output register feeds the tile's `noc_out_*` port toward the mesh router.

## Interface
- `FLIT_WIDTH`, 32: flit data width; equals the mesh's `NOC_FLIT_WIDTH`.
- `PORTS`, 4: number of requesters; legal range is 2 or more.
- `clk`  in  1: single clock for all logic.
- `rst_n`  in  1: reset, asynchronous and active-low; one clock, no other clock or reset.
- `in_flit`  in  `[PORTS-1:0][FLIT_WIDTH-1:0]`: requester flits.
- `in_last`  in  `[PORTS-1:0]`: marks the final flit of a packet.
- `in_valid`  in  `[PORTS-1:0]`: requester flit valid.
- `in_ready`  out  `[PORTS-1:0]`: flit accepted when `in_valid & in_ready`.
- `out_flit`  out  `FLIT_WIDTH`: registered flit toward the NoC.
- `out_last`  out  1: registered last marker.
- `out_valid`  out  1: registered valid.
- `out_ready`  in  1: NoC accepts when `out_valid & out_ready`.
- `grant`  out  `PORTS`: one-hot current owner; all zero in IDLE.

## Operation
- FSM states:
  - IDLE: no owner.
  - BUSY: `owner` is locked.
- IDLE behaviour:
  - If any `in_valid` is set, the owner is the first requester found searching from `ptr+1` upward, wrapping modulo PORTS.
  - Next state is BUSY. No flit is accepted in this cycle.
  - If no `in_valid` is set, the FSM stays in IDLE.
- BUSY behaviour:
  - `in_ready[owner] = !out_valid || out_ready`.
  - Every other `in_ready` bit is 0.
  - `in_valid` of non-owners is ignored; they may toggle freely.
- Accept behaviour:
  - On accept, `out_flit`, `out_last` and `out_valid` load from the owner's inputs on the next edge.
  - If the accepted flit has `in_last`=1, the FSM returns to IDLE and `ptr <= owner`.
- Output register:
  - If there is no accept and `out_ready` is 1, `out_valid` clears.
  - `out_flit` and `out_last` hold their values while `out_valid` is 1 and `out_ready` is 0.
- Owner behaviour:
  - The owner may drop `in_valid` mid-packet. The lock is held with no timeout.
- `ptr` is `$clog2(PORTS)` bits wide. The round-robin search index is computed modulo PORTS, which covers PORTS values that are not a power of 2.
- `grant` equals one-hot(`owner`) in BUSY and is 0 in IDLE.

## Timing
- Reset values (asynchronous, with `rst_n` low):
  - state = IDLE, `owner` = 0, `ptr` = PORTS-1, so port 0 wins first.
  - `out_valid` = 0, `out_flit` = 0, `out_last` = 0, `grant` = 0, `in_ready` = 0.
- Arbitration costs exactly 1 bubble cycle per packet: the IDLE cycle.
- Latency from input accept to `out_valid` is 1 cycle.
- With `out_ready` held at 1, throughput inside a packet is 1 flit per cycle.
- Single-flit packet (`last` on the first flit): BUSY lasts 1 cycle, then the FSM returns to IDLE.
- Output backpressure: with `out_ready`=0 and `out_valid`=1, `in_ready` is 0 and nothing changes.
- Ready path: `in_ready` depends combinationally on `out_ready`. This is the only combinational input-to-output path.
- Reset mid-packet: all state clears immediately, and the partial packet is dropped on both sides. The system reset owns recovery.
- New owner after release: a requester that raises `in_valid` in the same cycle as the `last` accept is eligible at the following IDLE.

## Structure
- Package `mpsoc_noc_arb_pkg` holds `typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t`.
- Sub-module `mpsoc_noc_rr_select`: purely combinational.
  - Inputs: `req[PORTS]` and `ptr`.
  - Outputs: `sel` index and `any`.
  - Instantiated once; the FSM and output register live in the top module.

## Test plan
- Single requester: 3-flit packet on port 1, `out_ready`=1.
  - `grant` goes to 4'b0010 one cycle after `in_valid`.
  - Flits appear on `out_*` on 3 consecutive cycles with `out_last` on the third.
  - FSM returns to IDLE.
- Contention: ports 0, 2 and 3 each hold a 2-flit packet from reset.
  - Grant order is 0, 2, 3, then 0 again.
  - Packets are never interleaved.
  - Each packet costs 1 bubble cycle.
- Backpressure: `out_ready`=0 for 4 cycles in the middle of a packet.
  - `out_flit` stays stable.
  - `in_ready[owner]` stays 0.
  - No flit is lost or duplicated after release.
- Wrap: PORTS=3, port 2 is the last owner, ports 0 and 1 request.
  - Port 0 wins, then port 1.
- Owner stall: the owner drops `in_valid` for 5 cycles mid-packet while port 3 requests.
  - `grant` stays on the owner.
  - Port 3 is granted only after the owner's `last` is accepted.
- Reset mid-packet: `rst_n` is asserted asynchronously during flit 2 of 4.
  - All outputs go to their reset values without waiting for a clock edge.
  - After release, port 0 wins first.
